// File: rtl/pooling_average_divide_if.sv
// BRAM read port and packed-result stream of the average-pool divide stage.
// The master side is the divide block; the slave side is BRAM plus the consumer.
interface pooling_average_divide_if #(
    parameter int SUM_W = 32
);
    logic [31:0]      rd_addr;
    logic [SUM_W-1:0] rd_data;
    logic [31:0]      out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output rd_addr,
        input  rd_data,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  rd_addr,
        output rd_data,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/pooling_average_divide.sv
// Walks per-channel window sums and scales each one by a Q0.16 reciprocal.
// Results are rounded and saturated to 8 bits, then packed four per word.
module pooling_average_divide #(
    parameter int SUM_W   = 32,
    parameter int RECIP_W = 16,
    parameter int CH_W    = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_start,
    input  logic [CH_W-1:0]          i_num_ch,
    input  logic [RECIP_W-1:0]       i_recip,
    input  logic [31:0]              i_base_addr,
    pooling_average_divide_if.master bus,
    output logic                     o_busy,
    output logic                     o_done
);
    localparam int PW = SUM_W + RECIP_W;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_MUL     = 3'd3;
    localparam logic [2:0] S_OUT     = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [CH_W-1:0]    r_num_ch;
    logic [RECIP_W-1:0] r_recip;
    logic [31:0]        r_base;
    logic [CH_W-1:0]    r_ch;
    logic [SUM_W-1:0]   r_sum;
    logic [3:0][7:0]    r_pack;
    logic [31:0]        r_rd_addr;
    logic               r_out_valid;
    logic               r_busy;
    logic               r_done;

    logic [PW-1:0]      w_prod;
    logic [PW:0]        w_rnd;
    logic [PW:0]        w_q;
    logic [7:0]         w_res;
    logic [CH_W:0]      w_ch_inc;
    logic               w_last;
    logic               w_word_full;
    logic               w_all_done;

    // Round half up: add 0.5 LSB of the Q16 product before dropping the fraction.
    assign w_prod      = PW'(r_sum) * PW'(r_recip);
    assign w_rnd       = {1'b0, w_prod} + (PW+1)'(32768);
    assign w_q         = w_rnd >> 16;
    assign w_res       = (|w_q[PW:8]) ? 8'hFF : w_q[7:0];

    assign w_ch_inc    = {1'b0, r_ch} + (CH_W+1)'(1);
    assign w_last      = (w_ch_inc == {1'b0, r_num_ch});
    assign w_word_full = (r_ch[1:0] == 2'd3);
    // In OUT, r_ch has already been advanced past the last written lane.
    assign w_all_done  = (r_ch == r_num_ch);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_state_nxt = (i_num_ch == '0) ? S_DONE : S_ISSUE;
            S_ISSUE:   w_state_nxt = S_CAPTURE;
            S_CAPTURE: w_state_nxt = S_MUL;
            S_MUL:     w_state_nxt = (w_word_full || w_last) ? S_OUT : S_ISSUE;
            S_OUT:     if (bus.out_ready) w_state_nxt = w_all_done ? S_DONE : S_ISSUE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_num_ch    <= '0;
            r_recip     <= '0;
            r_base      <= '0;
            r_ch        <= '0;
            r_sum       <= '0;
            r_pack      <= '0;
            r_rd_addr   <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            // Status outputs track the next state so they come straight from flops.
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= (w_state_nxt == S_DONE);
            r_out_valid <= (w_state_nxt == S_OUT);
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_num_ch <= i_num_ch;
                        r_recip  <= i_recip;
                        r_base   <= i_base_addr;
                        r_ch     <= '0;
                        r_pack   <= '0;
                    end
                end
                S_ISSUE:   r_rd_addr <= r_base + 32'(r_ch);
                S_CAPTURE: r_sum <= bus.rd_data;
                S_MUL: begin
                    r_pack[r_ch[1:0]] <= w_res;
                    r_ch              <= r_ch + 1'b1;
                end
                S_OUT: begin
                    // Clearing here leaves unused lanes of a partial last word at zero.
                    if (bus.out_ready) r_pack <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.rd_addr   = r_rd_addr;
    assign bus.out_data  = r_pack;
    assign bus.out_valid = r_out_valid;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
endmodule

// File: tb/tb_pooling_average_divide.sv
// Directed bench for pooling_average_divide: table-driven single-word passes
// plus hand sequences for backpressure, empty pass, ignored start and reset.
module tb_pooling_average_divide;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] num_ch;
    logic [15:0] recip;
    logic [31:0] base_addr;
    logic        busy;
    logic        done;

    pooling_average_divide_if #(.SUM_W(32)) bus_if ();

    pooling_average_divide #(.SUM_W(32), .RECIP_W(16), .CH_W(16)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_start     (start),
        .i_num_ch    (num_ch),
        .i_recip     (recip),
        .i_base_addr (base_addr),
        .bus         (bus_if),
        .o_busy      (busy),
        .o_done      (done)
    );

    always #5 clk = ~clk;

    // BRAM model: read data follows the registered address
    logic [31:0] mem [0:7];
    logic [31:0] cur_base;
    always_comb bus_if.rd_data = mem[3'(bus_if.rd_addr - cur_base)];

    int checks = 0;
    int errors = 0;

    logic [31:0] addr_log[$];
    logic [31:0] word_log[$];
    logic [31:0] last_addr = '0;
    int          done_cnt  = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus_if.out_valid && bus_if.out_ready) word_log.push_back(bus_if.out_data);
            if (done) done_cnt++;
            if (bus_if.rd_addr != last_addr) begin
                addr_log.push_back(bus_if.rd_addr);
                last_addr = bus_if.rd_addr;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pass(input logic [15:0] n, input logic [15:0] r, input logic [31:0] b);
        num_ch    = n;
        recip     = r;
        base_addr = b;
        cur_base  = b;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        addr_log.delete();
        word_log.delete();
        done_cnt  = 0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 300) begin
            tick();
            cyc++;
        end
        if (!done) check("done_timeout", 32'(cyc), 32'hFFFF_FFFF);
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!bus_if.out_valid && cyc < 300) begin
            tick();
            cyc++;
        end
        if (!bus_if.out_valid) check("valid_timeout", 32'(cyc), 32'hFFFF_FFFF);
    endtask

    task automatic check_addrs(input string name, input int n, input logic [31:0] b);
        check({name, "_naddr"}, 32'(addr_log.size()), 32'(n));
        for (int i = 0; i < n && i < addr_log.size(); i++)
            check({name, "_addr"}, addr_log[i], b + 32'(i));
    endtask

    typedef struct {
        string       name;
        logic [15:0] recip;
        logic [31:0] base;
        logic [31:0] s0, s1, s2, s3;
        logic [31:0] exp_word;
    } vec_t;

    vec_t vecs[3];

    initial begin
        int cyc;
        logic [31:0] held;

        vecs[0] = '{"avg7x7", 16'd1337,  32'h0000_1000, 32'd4900, 32'd0,   32'd49,         32'd2450, 32'h3201_0064};
        vecs[1] = '{"round",  16'd32768, 32'h0000_2000, 32'd3,    32'd2,   32'd1,          32'd5,    32'h0301_0102};
        vecs[2] = '{"satur",  16'd65535, 32'h0000_3000, 32'd255,  32'd256, 32'h00FF_FFFF,  32'd0,    32'h00FF_FFFF};

        reset = 1'b1; start = 1'b0; num_ch = '0; recip = '0; base_addr = '0; cur_base = '0;
        bus_if.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) mem[i] = '0;
        tick(); tick();
        check("rst_rd_addr",   bus_if.rd_addr,          32'h0);
        check("rst_out_data",  bus_if.out_data,         32'h0);
        check("rst_out_valid", 32'(bus_if.out_valid),   32'h0);
        check("rst_busy",      32'(busy),               32'h0);
        check("rst_done",      32'(done),               32'h0);
        reset = 1'b0;
        tick();

        // Single-word passes with out_ready tied high
        for (int v = 0; v < 3; v++) begin
            mem[0] = vecs[v].s0; mem[1] = vecs[v].s1; mem[2] = vecs[v].s2; mem[3] = vecs[v].s3;
            start_pass(16'd4, vecs[v].recip, vecs[v].base);
            check({vecs[v].name, "_busy"}, 32'(busy), 32'h1);
            wait_done(cyc);
            // done visible in cycle 3N+ceil(N/4)+1 after start, low one cycle later
            check({vecs[v].name, "_done_cyc"}, 32'(cyc), 32'd13);
            check({vecs[v].name, "_nwords"}, 32'(word_log.size()), 32'd1);
            if (word_log.size() > 0) check({vecs[v].name, "_word"}, word_log[0], vecs[v].exp_word);
            check_addrs(vecs[v].name, 4, vecs[v].base);
            tick();
            check({vecs[v].name, "_done_low"}, 32'(done), 32'h0);
            check({vecs[v].name, "_idle"},     32'(busy), 32'h0);
            check({vecs[v].name, "_ndone"},    32'(done_cnt), 32'd1);
            tick();
        end

        // Partial word with backpressure on both words
        for (int i = 0; i < 6; i++) mem[i] = 32'(i + 1);
        bus_if.out_ready = 1'b0;
        start_pass(16'd6, 16'd65535, 32'h0000_0100);
        wait_valid(cyc);
        check("bp_valid_cyc", 32'(cyc), 32'd12);
        for (int w = 0; w < 2; w++) begin
            if (w == 1) wait_valid(cyc);
            held = bus_if.out_data;
            for (int k = 0; k < 5; k++) begin
                tick();
                check("bp_stable", bus_if.out_data, held);
                check("bp_valid_hold", 32'(bus_if.out_valid), 32'h1);
                check("bp_no_issue", 32'(addr_log.size()), (w == 0) ? 32'd4 : 32'd6);
            end
            bus_if.out_ready = 1'b1;
            tick();
            bus_if.out_ready = 1'b0;
            check("bp_valid_drop", 32'(bus_if.out_valid), 32'h0);
        end
        wait_done(cyc);
        check("bp_nwords", 32'(word_log.size()), 32'd2);
        if (word_log.size() == 2) begin
            check("bp_word0", word_log[0], 32'h0403_0201);
            check("bp_word1", word_log[1], 32'h0000_0605);
        end
        check_addrs("bp", 6, 32'h0000_0100);
        bus_if.out_ready = 1'b1;
        tick(); tick();

        // Empty pass: straight to done, no output
        start_pass(16'd0, 16'd1337, 32'h0000_0200);
        check("empty_done", 32'(done), 32'h1);
        check("empty_valid", 32'(bus_if.out_valid), 32'h0);
        tick();
        check("empty_done_low", 32'(done), 32'h0);
        check("empty_idle", 32'(busy), 32'h0);
        check("empty_nwords", 32'(word_log.size()), 32'd0);
        tick();

        // Start pulsed mid-pass with different config must be ignored
        mem[0] = 32'd3; mem[1] = 32'd2; mem[2] = 32'd1; mem[3] = 32'd5;
        start_pass(16'd4, 16'd32768, 32'h0000_0040);
        tick(); tick(); tick(); tick();
        num_ch = 16'd1; recip = 16'd1; base_addr = 32'h0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(cyc);
        check("ign_nwords", 32'(word_log.size()), 32'd1);
        if (word_log.size() > 0) check("ign_word", word_log[0], 32'h0301_0102);
        check_addrs("ign", 4, 32'h0000_0040);
        tick(); tick();

        // Reset while a word is waiting in OUT
        bus_if.out_ready = 1'b0;
        start_pass(16'd4, 16'd32768, 32'h0000_0080);
        wait_valid(cyc);
        check("rst_out_valid_pre", 32'(bus_if.out_valid), 32'h1);
        reset = 1'b1;
        tick();
        check("rst_mid_valid", 32'(bus_if.out_valid), 32'h0);
        check("rst_mid_busy",  32'(busy), 32'h0);
        check("rst_mid_done",  32'(done), 32'h0);
        reset = 1'b0;
        bus_if.out_ready = 1'b1;
        tick(); tick();
        check("rst_mid_ndone", 32'(done_cnt), 32'd0);
        mem[0] = 32'd255; mem[1] = 32'd256; mem[2] = 32'h00FF_FFFF; mem[3] = 32'd0;
        start_pass(16'd4, 16'd65535, 32'h0000_00C0);
        wait_done(cyc);
        check("post_rst_cyc", 32'(cyc), 32'd13);
        check("post_rst_nwords", 32'(word_log.size()), 32'd1);
        if (word_log.size() > 0) check("post_rst_word", word_log[0], 32'h00FF_FFFF);
        check_addrs("post_rst", 4, 32'h0000_00C0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
